// File: rtl/uart_program_loader.sv
// uart_program_loader
//   Parses framed program images arriving byte-by-byte from a UART receiver and
//   writes them, one DATA_WIDTH word at a time, into instruction memory starting
//   at address 0.
//   Frame: SYNC_BYTE, LEN_HI, LEN_LO, LEN*BYTES payload bytes, CKSUM
//   LEN is the image length in words.
//   CKSUM is the 8-bit sum of LEN_HI, LEN_LO and every payload byte.
//
// Ports
//   clock         system clock, all logic on posedge
//   i_reset_n     asynchronous active-low reset
//   i_data_avail  one-cycle byte strobe from the UART receiver
//   i_data_byte   received byte, valid with i_data_avail
//   o_mem_we      one-cycle instruction-memory write strobe
//   o_mem_addr    write address, valid with o_mem_we
//   o_mem_data    write data (big-endian packed), valid with o_mem_we
//   o_busy        a frame is being received
//   o_done        last frame loaded with a correct checksum (level)
//   o_error       last frame failed: length, checksum or timeout (level)
module uart_program_loader #(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter int unsigned TIMEOUT_CLKS = 520800
) (
  input  logic                  clock,
  input  logic                  i_reset_n,
  input  logic                  i_data_avail,
  input  logic [7:0]            i_data_byte,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CLKS + 1);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BYTES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CLKS - 1);
  localparam logic [32:0]      MAX_LEN  = 33'd1 << ADDR_WIDTH;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_HI = 3'd1;
  localparam logic [2:0] S_LEN_LO = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_CHECK  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_ERROR  = 3'd6;

  logic [2:0]            r_state;
  logic [7:0]            r_len_hi;
  logic [15:0]           r_words_left;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [IDX_W-1:0]      r_idx;
  logic [DATA_WIDTH-1:0] r_word;
  logic [7:0]            r_cksum;
  logic [TO_W-1:0]       r_timer;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_data;

  logic                  w_busy;
  logic                  w_timeout;
  logic [7:0]            w_cksum_next;
  logic [15:0]           w_len;
  logic [DATA_WIDTH-1:0] w_word_next;

  assign w_busy = (r_state == S_LEN_HI) || (r_state == S_LEN_LO) ||
                  (r_state == S_DATA)   || (r_state == S_CHECK);

  // A byte in the limit cycle takes priority over the timeout.
  assign w_timeout    = w_busy && !i_data_avail && (r_timer == TO_LAST);
  assign w_cksum_next = r_cksum + i_data_byte;
  assign w_len        = {r_len_hi, i_data_byte};

  // Byte index 0 lands in the most significant byte lane.
  always_comb begin
    w_word_next = r_word;
    for (int unsigned b = 0; b < BYTES; b++) begin
      if (r_idx == IDX_W'(BYTES - 1 - b)) begin
        w_word_next[b*8 +: 8] = i_data_byte;
      end
    end
  end

  always_ff @(posedge clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state      <= S_IDLE;
      r_len_hi     <= '0;
      r_words_left <= '0;
      r_addr       <= '0;
      r_idx        <= '0;
      r_word       <= '0;
      r_cksum      <= '0;
      r_timer      <= '0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_data   <= '0;
    end else begin
      r_mem_we <= 1'b0;

      if (!w_busy || i_data_avail || w_timeout) begin
        r_timer <= '0;
      end else begin
        r_timer <= r_timer + 1'b1;
      end

      if (w_timeout) begin
        r_state <= S_ERROR;
      end else if (i_data_avail) begin
        case (r_state)
          S_IDLE, S_DONE, S_ERROR: begin
            if (i_data_byte == SYNC_BYTE) begin
              r_state <= S_LEN_HI;
              r_cksum <= '0;
            end
          end
          S_LEN_HI: begin
            r_len_hi <= i_data_byte;
            r_cksum  <= w_cksum_next;
            r_state  <= S_LEN_LO;
          end
          S_LEN_LO: begin
            r_cksum <= w_cksum_next;
            if ({17'd0, w_len} > MAX_LEN) begin
              r_state <= S_ERROR;
            end else if (w_len == 16'd0) begin
              r_state <= S_CHECK;
            end else begin
              r_state      <= S_DATA;
              r_words_left <= w_len;
              r_addr       <= '0;
              r_idx        <= '0;
            end
          end
          S_DATA: begin
            r_cksum <= w_cksum_next;
            r_word  <= w_word_next;
            if (r_idx == IDX_LAST) begin
              r_mem_we   <= 1'b1;
              r_mem_addr <= r_addr;
              r_mem_data <= w_word_next;
              r_idx      <= '0;
              // Address is held on the last word so it never wraps.
              if (r_words_left == 16'd1) begin
                r_state <= S_CHECK;
              end else begin
                r_addr       <= r_addr + 1'b1;
                r_words_left <= r_words_left - 16'd1;
              end
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
          S_CHECK: begin
            r_state <= (i_data_byte == r_cksum) ? S_DONE : S_ERROR;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign o_mem_we   = r_mem_we;
  assign o_mem_addr = r_mem_addr;
  assign o_mem_data = r_mem_data;
  assign o_busy     = w_busy;
  assign o_done     = (r_state == S_DONE);
  assign o_error    = (r_state == S_ERROR);

endmodule

// File: tb/tb_uart_program_loader.sv
// tb_uart_program_loader
//   Randomized and directed frame stimulus for uart_program_loader, checked
//   against a frame-level reference model: expected writes and final status
//   are derived from the payload list, the length and the 8-bit byte sum.
module tb_uart_program_loader;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 8;
  localparam int unsigned TO = 40;

  logic          clock = 1'b0;
  logic          i_reset_n = 1'b0;
  logic          i_data_avail = 1'b0;
  logic [7:0]    i_data_byte = 8'h00;
  logic          o_mem_we;
  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] o_mem_data;
  logic          o_busy;
  logic          o_done;
  logic          o_error;

  int unsigned n_cmp = 0;
  int unsigned n_mis = 0;

  logic [23:0] q_obs[$];

  uart_program_loader #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .SYNC_BYTE   (8'hA5),
    .TIMEOUT_CLKS(TO)
  ) dut (
    .clock       (clock),
    .i_reset_n   (i_reset_n),
    .i_data_avail(i_data_avail),
    .i_data_byte (i_data_byte),
    .o_mem_we    (o_mem_we),
    .o_mem_addr  (o_mem_addr),
    .o_mem_data  (o_mem_data),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_error     (o_error)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (i_reset_n && o_mem_we) q_obs.push_back({o_mem_addr, o_mem_data});
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b, input bit gaps);
    if (gaps) idle($urandom_range(0, 3));
    i_data_avail = 1'b1;
    i_data_byte  = b;
    @(posedge clock);
    #1;
    i_data_avail = 1'b0;
    i_data_byte  = 8'($urandom);
  endtask

  task automatic check_status(input string tag, input bit busy, input bit done, input bit err);
    check({tag, "_busy"},  32'(o_busy),  32'(busy));
    check({tag, "_done"},  32'(o_done),  32'(done));
    check({tag, "_error"}, 32'(o_error), 32'(err));
  endtask

  // Sends one frame (optionally preceded by junk bytes) and checks writes and status.
  task automatic run_frame(input int unsigned len, input logic [7:0] pay[$],
                           input bit force_ck, input logic [7:0] ck_val,
                           input int unsigned junk, input bit gaps);
    logic [15:0] len16;
    logic [7:0]  sum;
    logic [7:0]  ck;
    logic [7:0]  pb;
    logic [15:0] word;
    logic [23:0] exp_q[$];
    int unsigned k;
    bit          good;
    len16 = 16'(len);
    q_obs.delete();
    for (int unsigned j = 0; j < junk; j++) begin
      pb = 8'($urandom);
      if (pb == 8'hA5) pb = 8'h5A;
      send(pb, gaps);
    end
    send(8'hA5, gaps);
    check_status("sync", 1'b1, 1'b0, 1'b0);
    send(len16[15:8], gaps);
    send(len16[7:0], gaps);
    sum = len16[15:8] + len16[7:0];
    if (len > (1 << AW)) begin
      check_status("len_over", 1'b0, 1'b0, 1'b1);
      idle(3);
      check("len_over_writes", 32'(q_obs.size()), 32'd0);
      return;
    end
    for (int unsigned w = 0; w < len; w++) begin
      word = 16'h0000;
      for (int unsigned b = 0; b < 2; b++) begin
        k  = w * 2 + b;
        pb = (k < pay.size()) ? pay[k] : 8'($urandom);
        word = (word << 8) | 16'(pb);
        sum  = sum + pb;
        send(pb, gaps);
        check("we_pulse", 32'(o_mem_we), (b == 1) ? 32'd1 : 32'd0);
      end
      exp_q.push_back({8'(w), word});
    end
    ck   = force_ck ? ck_val : sum;
    good = (ck == sum);
    send(ck, gaps);
    check_status("final", 1'b0, good, !good);
    idle(1);
    check("write_count", 32'(q_obs.size()), 32'(exp_q.size()));
    for (int unsigned i = 0; i < exp_q.size() && i < q_obs.size(); i++) begin
      check("write_addr", 32'(q_obs[i][23:16]), 32'(exp_q[i][23:16]));
      check("write_data", 32'(q_obs[i][15:0]),  32'(exp_q[i][15:0]));
    end
  endtask

  initial begin
    logic [7:0]  pq[$];
    int unsigned len;
    int unsigned sel;

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    check_status("reset", 1'b0, 1'b0, 1'b0);
    check("reset_we",   32'(o_mem_we),   32'd0);
    check("reset_addr", 32'(o_mem_addr), 32'd0);
    check("reset_data", 32'(o_mem_data), 32'd0);
    i_reset_n = 1'b1;
    idle(2);

    // 1: two-word image with correct checksum C0
    pq = '{8'h12, 8'h34, 8'hAB, 8'hCD};
    run_frame(2, pq, 1'b1, 8'hC0, 0, 1'b0);

    // 2: same image, wrong checksum; writes remain, error raised
    run_frame(2, pq, 1'b1, 8'hC1, 0, 1'b0);

    // 3: length 257 exceeds 2**ADDR_WIDTH
    pq.delete();
    run_frame(257, pq, 1'b0, 8'h00, 0, 1'b0);

    // 4: leading junk then empty image
    q_obs.delete();
    send(8'h00, 1'b0);
    send(8'hFF, 1'b0);
    check_status("junk", 1'b0, 1'b0, 1'b1);
    run_frame(0, pq, 1'b1, 8'h00, 0, 1'b0);

    // 5a: timeout TO clocks after the last byte
    q_obs.delete();
    send(8'hA5, 1'b0);
    send(8'h00, 1'b0);
    send(8'h01, 1'b0);
    send(8'h12, 1'b0);
    idle(TO - 1);
    check_status("to_before", 1'b1, 1'b0, 1'b0);
    idle(1);
    check_status("to_hit", 1'b0, 1'b0, 1'b1);
    idle(2);
    check("to_writes", 32'(q_obs.size()), 32'd0);

    // 5b: byte arrives in the limit cycle and wins
    q_obs.delete();
    send(8'hA5, 1'b0);
    send(8'h00, 1'b0);
    send(8'h01, 1'b0);
    send(8'h12, 1'b0);
    idle(TO - 1);
    send(8'h34, 1'b0);
    check_status("to_edge", 1'b1, 1'b0, 1'b0);
    check("to_edge_we", 32'(o_mem_we), 32'd1);
    send(8'h47, 1'b0);
    check_status("to_edge_final", 1'b0, 1'b1, 1'b0);
    idle(1);
    check("to_edge_count", 32'(q_obs.size()), 32'd1);
    if (q_obs.size() > 0) check("to_edge_word", 32'(q_obs[0]), 32'h001234);

    // 6: asynchronous reset mid-DATA, then a clean reload from address 0
    send(8'hA5, 1'b0);
    send(8'h00, 1'b0);
    send(8'h02, 1'b0);
    send(8'h12, 1'b0);
    send(8'h34, 1'b0);
    send(8'hAB, 1'b0);
    #1 i_reset_n = 1'b0;
    #1;
    check_status("midreset", 1'b0, 1'b0, 1'b0);
    check("midreset_we",   32'(o_mem_we),   32'd0);
    check("midreset_addr", 32'(o_mem_addr), 32'd0);
    check("midreset_data", 32'(o_mem_data), 32'd0);
    #1 i_reset_n = 1'b1;
    idle(2);
    pq = '{8'h12, 8'h34, 8'hAB, 8'hCD};
    run_frame(2, pq, 1'b0, 8'h00, 0, 1'b0);

    // Randomized frames, including the 2**ADDR_WIDTH boundary and oversize lengths
    pq.delete();
    for (int unsigned f = 0; f < 30; f++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0)      len = 1 << AW;
      else if (sel == 1) len = $urandom_range(257, 65535);
      else               len = $urandom_range(0, 6);
      run_frame(len, pq, ($urandom_range(0, 3) == 0), 8'($urandom),
                $urandom_range(0, 2), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
